// File: rtl/ssn_output_pipe_multistage_if.sv
// Stream bus bundle for the multistage output pipe: data, mode/flush controls and status.
interface ssn_output_pipe_multistage_if #(
   parameter int unsigned WIDTH = 20,
   parameter int unsigned DEPTH = 2
);
   localparam int unsigned FILL_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0]  bus_data_in;
   logic [WIDTH-1:0]  bus_data_out;
   logic              pipe_bypass;
   logic              pipe_flush;
   logic              bus_out_valid;
   logic [FILL_W-1:0] fill_level;

   // Producer side: drives stream data and controls, observes the pipe output.
   modport master (
      output bus_data_in, pipe_bypass, pipe_flush,
      input  bus_data_out, bus_out_valid, fill_level
   );

   // Pipe side.
   modport slave (
      input  bus_data_in, pipe_bypass, pipe_flush,
      output bus_data_out, bus_out_valid, fill_level
   );
endinterface

// File: rtl/ssn_output_pipe_multistage.sv
// Multistage output register pipe with bypass, flush, valid tracking and a
// reset-release synchronizer. Data stages carry no reset; the valid chain does.
module ssn_output_pipe_multistage #(
   parameter int unsigned WIDTH       = 20,
   parameter int unsigned DEPTH       = 2,
   parameter int unsigned SYNC_STAGES = 2
) (
   input logic                        bus_clock,
   input logic                        ijtag_reset,
   ssn_output_pipe_multistage_if.slave bus
);
   localparam int unsigned FILL_W = $clog2(DEPTH + 1);

   // Reject unsupported configurations at elaboration.
   if (DEPTH == 0 || DEPTH > 8) begin : g_bad_depth
      $error("ssn_output_pipe_multistage: DEPTH must be 1..8");
   end
   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("ssn_output_pipe_multistage: SYNC_STAGES must be 2..4");
   end
   if (WIDTH == 0 || WIDTH > 64) begin : g_bad_width
      $error("ssn_output_pipe_multistage: WIDTH must be 1..64");
   end

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [WIDTH-1:0]       s_q [DEPTH];
   logic [WIDTH-1:0]       s_d [DEPTH];
   logic [DEPTH-1:0]       v_q, v_d;
   logic [FILL_W-1:0]      fill_q, fill_d;
   logic                   sync_reset;
   logic                   clear_c;

   assign sync_reset = sync_q[SYNC_STAGES-1];
   // Reset dominates flush; both simply empty the pipe.
   assign clear_c    = sync_reset | bus.pipe_flush;

   // Synchronizer shifts zeros in after release; last bit is the internal reset.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], 1'b0};
   end

   // Synchronizer register: forced all-ones while the external reset is low.
   always_ff @(posedge bus_clock or negedge ijtag_reset) begin
      if (!ijtag_reset) sync_q <= '1;
      else              sync_q <= sync_d;
   end

   // Next data stage contents: shift, or zero on reset/flush.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) s_d[i] = '0;
      if (!clear_c) begin
         s_d[0] = bus.bus_data_in;
         for (int i = 1; i < DEPTH; i++) s_d[i] = s_q[i-1];
      end
   end

   // Data stages: plain flops, cleared only through the synchronous path.
   always_ff @(posedge bus_clock) begin
      s_q <= s_d;
   end

   // Next valid chain and fill count; the chain is a thermometer so the count tracks it.
   always_comb begin
      v_d    = '0;
      fill_d = '0;
      if (!clear_c) begin
         v_d[0] = 1'b1;
         for (int i = 1; i < DEPTH; i++) v_d[i] = v_q[i-1];
         fill_d = (fill_q == FILL_W'(DEPTH)) ? fill_q : fill_q + FILL_W'(1);
      end
   end

   // Valid chain and fill count: cleared immediately by the external reset.
   always_ff @(posedge bus_clock or negedge ijtag_reset) begin
      if (!ijtag_reset) begin
         v_q    <= '0;
         fill_q <= '0;
      end else begin
         v_q    <= v_d;
         fill_q <= fill_d;
      end
   end

   // Output mux: bypass is a pure combinational path, gated by the internal reset.
   assign bus.bus_data_out  = bus.pipe_bypass ? (sync_reset ? '0 : bus.bus_data_in)
                                              : s_q[DEPTH-1];
   assign bus.bus_out_valid = bus.pipe_bypass ? ~sync_reset : v_q[DEPTH-1];
   assign bus.fill_level    = fill_q;

endmodule

// File: tb/tb_ssn_output_pipe_multistage.sv
// Directed bench: three configurations (D3/S2, D1/S4, D8/S4) share clock, reset and inputs.
module tb_ssn_output_pipe_multistage;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [19:0] din = '0;
   logic        bypass = 1'b0;
   logic        flush = 1'b0;

   int          checks = 0;
   int          errors = 0;
   int          ecount = 0;
   logic [19:0] hist [0:2047];

   always #5 clk = ~clk;

   ssn_output_pipe_multistage_if #(.WIDTH(20), .DEPTH(3)) if3 ();
   ssn_output_pipe_multistage_if #(.WIDTH(20), .DEPTH(1)) if1 ();
   ssn_output_pipe_multistage_if #(.WIDTH(20), .DEPTH(8)) if8 ();

   assign if3.bus_data_in = din;
   assign if3.pipe_bypass = bypass;
   assign if3.pipe_flush  = flush;
   assign if1.bus_data_in = din;
   assign if1.pipe_bypass = bypass;
   assign if1.pipe_flush  = flush;
   assign if8.bus_data_in = din;
   assign if8.pipe_bypass = bypass;
   assign if8.pipe_flush  = flush;

   ssn_output_pipe_multistage #(.WIDTH(20), .DEPTH(3), .SYNC_STAGES(2)) dut3 (
      .bus_clock(clk), .ijtag_reset(rst_n), .bus(if3));
   ssn_output_pipe_multistage #(.WIDTH(20), .DEPTH(1), .SYNC_STAGES(4)) dut1 (
      .bus_clock(clk), .ijtag_reset(rst_n), .bus(if1));
   ssn_output_pipe_multistage #(.WIDTH(20), .DEPTH(8), .SYNC_STAGES(4)) dut8 (
      .bus_clock(clk), .ijtag_reset(rst_n), .bus(if8));

   typedef struct {
      logic        bypass;
      logic        flush;
      logic [19:0] din;
      logic [19:0] exp_out;
      logic        exp_valid;
      int          exp_fill;
   } vec_t;

   vec_t tbl [15];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One rising edge; record the word the pipe samples on it, then settle.
   task automatic step();
      @(posedge clk);
      ecount++;
      hist[ecount] = din;
      #1;
   endtask

   // Expected behaviour n edges after reset release for a (SYNC, DEPTH) configuration.
   task automatic chk_gen(input string tag, input int n, input int s, input int d,
                          input logic [19:0] out, input logic v, input int fill);
      int   ef;
      logic ev;
      ef = (n <= s) ? 0 : (((n - s) > d) ? d : (n - s));
      ev = (n >= s + d);
      chk({tag, "_fill"}, 64'(fill), 64'(ef));
      chk({tag, "_valid"}, 64'(v), 64'(ev));
      if (ev) chk({tag, "_data"}, 64'(out), 64'(hist[ecount - d + 1]));
   endtask

   task automatic check_all(input int n);
      chk_gen("d3", n, 2, 3, if3.bus_data_out, if3.bus_out_valid, int'(if3.fill_level));
      chk_gen("d1", n, 4, 1, if1.bus_data_out, if1.bus_out_valid, int'(if1.fill_level));
      chk_gen("d8", n, 4, 8, if8.bus_data_out, if8.bus_out_valid, int'(if8.fill_level));
   endtask

   task automatic chk_all_cleared(input string tag);
      chk({tag, "_v3"}, 64'(if3.bus_out_valid), 64'(0));
      chk({tag, "_f3"}, 64'(if3.fill_level), 64'(0));
      chk({tag, "_v1"}, 64'(if1.bus_out_valid), 64'(0));
      chk({tag, "_f1"}, 64'(if1.fill_level), 64'(0));
      chk({tag, "_v8"}, 64'(if8.bus_out_valid), 64'(0));
      chk({tag, "_f8"}, 64'(if8.fill_level), 64'(0));
   endtask

   // Release reset mid-cycle and follow the recovery edge by edge.
   task automatic release_and_run(input int edges);
      #3 rst_n = 1'b1;
      #1;
      for (int n = 1; n <= edges; n++) begin
         din = 20'(ecount + 1);
         step();
         check_all(n);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // Steady-state sequence on the D3 pipe; each row is checked after its edge.
      tbl[0]  = '{1'b0, 1'b1, 20'h11111, 20'h00000, 1'b0, 0};
      tbl[1]  = '{1'b0, 1'b0, 20'h00A01, 20'h00000, 1'b0, 1};
      tbl[2]  = '{1'b0, 1'b0, 20'h00A02, 20'h00000, 1'b0, 2};
      tbl[3]  = '{1'b0, 1'b0, 20'h00A03, 20'h00A01, 1'b1, 3};
      tbl[4]  = '{1'b0, 1'b0, 20'h00A04, 20'h00A02, 1'b1, 3};
      tbl[5]  = '{1'b1, 1'b0, 20'hABCDE, 20'hABCDE, 1'b1, 3};
      tbl[6]  = '{1'b1, 1'b0, 20'h12345, 20'h12345, 1'b1, 3};
      tbl[7]  = '{1'b0, 1'b0, 20'h00B01, 20'hABCDE, 1'b1, 3};
      tbl[8]  = '{1'b0, 1'b1, 20'h00B02, 20'h00000, 1'b0, 0};
      tbl[9]  = '{1'b0, 1'b1, 20'h00B03, 20'h00000, 1'b0, 0};
      tbl[10] = '{1'b0, 1'b0, 20'h00B04, 20'h00000, 1'b0, 1};
      tbl[11] = '{1'b0, 1'b0, 20'h00B05, 20'h00000, 1'b0, 2};
      tbl[12] = '{1'b0, 1'b0, 20'h00B06, 20'h00B04, 1'b1, 3};
      tbl[13] = '{1'b1, 1'b1, 20'h55555, 20'h55555, 1'b1, 0};
      tbl[14] = '{1'b0, 1'b0, 20'h00C01, 20'h00000, 1'b0, 1};

      // Power-on reset: status cleared before any clock edge.
      #1 rst_n = 1'b0;
      #2;
      chk_all_cleared("por");
      bypass = 1'b1;
      din    = 20'hFFFFF;
      #1;
      chk("por_bypass_out", 64'(if3.bus_data_out), 64'(0));
      chk("por_bypass_valid", 64'(if3.bus_out_valid), 64'(0));
      bypass = 1'b0;

      // Five clocked reset cycles: outputs forced to zero from the first edge.
      for (int i = 0; i < 5; i++) begin
         din = 20'(ecount + 1);
         step();
         chk("rst_out3", 64'(if3.bus_data_out), 64'(0));
         chk("rst_out1", 64'(if1.bus_data_out), 64'(0));
         chk("rst_out8", 64'(if8.bus_data_out), 64'(0));
         chk("rst_valid3", 64'(if3.bus_out_valid), 64'(0));
      end

      // Release and stream an incrementing count through all three configurations.
      release_and_run(1020);

      // Flush and bypass corner sequence on the D3 pipe.
      for (int r = 0; r < 15; r++) begin
         bypass = tbl[r].bypass;
         flush  = tbl[r].flush;
         din    = tbl[r].din;
         step();
         chk($sformatf("tbl%0d_out", r), 64'(if3.bus_data_out), 64'(tbl[r].exp_out));
         chk($sformatf("tbl%0d_valid", r), 64'(if3.bus_out_valid), 64'(tbl[r].exp_valid));
         chk($sformatf("tbl%0d_fill", r), 64'(if3.fill_level), 64'(tbl[r].exp_fill));
      end
      bypass = 1'b0;
      flush  = 1'b0;

      // Refill every configuration before the mid-stream reset.
      for (int i = 0; i < 12; i++) begin
         din = 20'(ecount + 1);
         step();
      end
      chk("pre_rst_valid3", 64'(if3.bus_out_valid), 64'(1));
      chk("pre_rst_valid8", 64'(if8.bus_out_valid), 64'(1));

      // Asynchronous reset between edges: status drops without a clock.
      #3 rst_n = 1'b0;
      #1;
      chk_all_cleared("mid_rst");
      din = 20'h7FFFF;
      step();
      chk("mid_rst_out3", 64'(if3.bus_data_out), 64'(0));
      chk("mid_rst_out1", 64'(if1.bus_data_out), 64'(0));
      chk("mid_rst_out8", 64'(if8.bus_data_out), 64'(0));
      for (int i = 0; i < 2; i++) begin
         din = 20'(ecount + 1);
         step();
         chk_all_cleared("held_rst");
      end

      // Recovery after the mid-stream reset.
      release_and_run(16);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
